// File: rtl/data_pipe_arb_pkg.sv
// Shared types and helpers for the round-robin address arbiter in front of the
// M2S pipe interconnect.
package data_pipe_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Select index width: 1/2/3/4/5 bits for NUM <= 2/4/8/16/32.
  function automatic int calc_nsize(input int num);
    if (num <= 2)       return 1;
    else if (num <= 4)  return 2;
    else if (num <= 8)  return 3;
    else if (num <= 16) return 4;
    else                return 5;
  endfunction

  // Beat counter width; a limit of 0 (unbounded) still keeps one bit.
  function automatic int calc_csize(input int max_burst);
    int w;
    w = $clog2(max_burst + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num);
    return (idx == num - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/data_pipe_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping at NUM.
module data_pipe_rr_pick
  import data_pipe_arb_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int NSIZE = calc_nsize(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] ptr,
  output logic [NSIZE-1:0] idx,
  output logic             found
);

  int                 j;
  logic [NSIZE-1:0]   jj;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < NUM; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM) j = j - NUM;
      jj = NSIZE'(j);
      if (!found && req[jj]) begin
        idx   = jj;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_pipe_rr_addr_arbiter.sv
// Round-robin addr generator for the M2S pipe interconnect: holds a grant for
// up to MAX_BURST beats, then rotates to the next requester.
module data_pipe_rr_addr_arbiter
  import data_pipe_arb_pkg::*;
#(
  parameter int NUM       = 8,
  parameter int MAX_BURST = 16,
  parameter int NSIZE     = calc_nsize(NUM),
  parameter int CSIZE     = calc_csize(MAX_BURST)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [NUM-1:0]   s_valid,
  input  logic [NUM-1:0]   s_ready,
  output logic [NSIZE-1:0] addr,
  output logic             grant_vld,
  output logic [NUM-1:0]   grant_onehot,
  output logic             burst_done,
  output arb_state_e       dbg_state_o,
  output logic [NSIZE-1:0] dbg_ptr_o,
  output logic [CSIZE-1:0] dbg_cnt_o
);

  // Saturation point of the beat counter; with no burst limit it simply
  // parks at all-ones and is never used for release.
  localparam int               CNT_MAX_I = (MAX_BURST == 0) ? ((1 << CSIZE) - 1) : (MAX_BURST - 1);
  localparam logic [CSIZE-1:0] CNT_MAX   = CSIZE'(CNT_MAX_I);

  arb_state_e       state_q;
  logic [NSIZE-1:0] addr_q;
  logic [NSIZE-1:0] ptr_q;
  logic [CSIZE-1:0] cnt_q;
  logic             grant_vld_q;
  logic [NUM-1:0]   onehot_q;
  logic             burst_done_q;

  logic             hs;
  logic             burst_last;
  logic             release_gnt;
  logic [NSIZE-1:0] ptr_next;
  logic [NUM-1:0]   pick_req;
  logic [NSIZE-1:0] pick_ptr;
  logic [NSIZE-1:0] pick_idx;
  logic             pick_found;
  logic [NUM-1:0]   pick_onehot;

  // A beat transfers on the granted stream when both its valid and the
  // interconnect's ready are high in the same enabled cycle; other ready
  // bits are ignored.
  assign hs          = clk_en & grant_vld_q & s_valid[addr_q] & s_ready[addr_q];
  assign burst_last  = (MAX_BURST != 0) && hs && (cnt_q == CNT_MAX);
  assign release_gnt = burst_last || !s_valid[addr_q];
  assign ptr_next    = NSIZE'(wrap_inc(32'(addr_q), NUM));

  // In GRANT the pick looks ahead for the regrant target; a burst-limited
  // stream is masked so it cannot immediately win again.
  always_comb begin
    pick_req = s_valid;
    pick_ptr = ptr_q;
    if (state_q == GRANT) begin
      pick_ptr = ptr_next;
      if (burst_last) pick_req[addr_q] = 1'b0;
    end
  end

  data_pipe_rr_pick #(
    .NUM   (NUM),
    .NSIZE (NSIZE)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_onehot = NUM'(1) << pick_idx;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      grant_vld_q  <= 1'b0;
      onehot_q     <= '0;
      burst_done_q <= 1'b0;
    end else if (!clk_en) begin
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            addr_q      <= pick_idx;
            onehot_q    <= pick_onehot;
            grant_vld_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            burst_done_q <= 1'b1;
            ptr_q        <= ptr_next;
            if (pick_found) begin
              addr_q   <= pick_idx;
              onehot_q <= pick_onehot;
              cnt_q    <= '0;
            end else begin
              grant_vld_q <= 1'b0;
              onehot_q    <= '0;
              state_q     <= IDLE;
            end
          end else if (hs && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          grant_vld_q <= 1'b0;
          onehot_q    <= '0;
        end
      endcase
    end
  end

  assign addr         = addr_q;
  assign grant_vld    = grant_vld_q;
  assign grant_onehot = onehot_q;
  assign burst_done   = burst_done_q;
  assign dbg_state_o  = state_q;
  assign dbg_ptr_o    = ptr_q;
  assign dbg_cnt_o    = cnt_q;

endmodule

// File: tb/tb_data_pipe_rr_addr_arbiter.sv
// Directed bench for the round-robin addr arbiter, NUM=4, MAX_BURST=4.
module tb_data_pipe_rr_addr_arbiter;
  import data_pipe_arb_pkg::*;

  localparam int NUM       = 4;
  localparam int MAX_BURST = 4;
  localparam int NSIZE     = 2;
  localparam int CSIZE     = 3;

  logic             clock;
  logic             rst_n;
  logic             clk_en;
  logic [NUM-1:0]   s_valid;
  logic [NUM-1:0]   s_ready;
  logic [NSIZE-1:0] addr;
  logic             grant_vld;
  logic [NUM-1:0]   grant_onehot;
  logic             burst_done;
  arb_state_e       dbg_state;
  logic [NSIZE-1:0] dbg_ptr;
  logic [CSIZE-1:0] dbg_cnt;

  int total = 0;
  int bad   = 0;

  data_pipe_rr_addr_arbiter #(
    .NUM       (NUM),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .addr         (addr),
    .grant_vld    (grant_vld),
    .grant_onehot (grant_onehot),
    .burst_done   (burst_done),
    .dbg_state_o  (dbg_state),
    .dbg_ptr_o    (dbg_ptr),
    .dbg_cnt_o    (dbg_cnt)
  );

  // clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int a, input logic gv, input logic bd);
    chk({tag, "_addr"}, 32'(addr), 32'(a));
    chk({tag, "_gv"}, 32'(grant_vld), 32'(gv));
    chk({tag, "_bd"}, 32'(burst_done), 32'(bd));
    chk({tag, "_oh"}, 32'(grant_onehot), gv ? (32'd1 << a) : 32'd0);
  endtask

  initial begin
    int exp_a;
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    s_valid = '0;
    s_ready = '0;
    step();
    step();
    chk_grant("rst", 0, 1'b0, 1'b0);
    chk("rst_ptr", 32'(dbg_ptr), 32'd0);
    chk("rst_cnt", 32'(dbg_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();
    chk("idle_hold_gv", 32'(grant_vld), 32'd0);

    // 1: two requesters, back-to-back rotation every 4 beats
    s_valid = 4'b0110;
    s_ready = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      step();
      exp_a = (k < 4 || k == 8) ? 1 : 2;
      chk_grant($sformatf("t1_k%0d", k), exp_a, 1'b1, (k == 4 || k == 8));
    end
    s_valid = '0;
    step();
    chk_grant("t1_drop", 1, 1'b0, 1'b1);
    chk("t1_drop_ptr", 32'(dbg_ptr), 32'd2);
    step();
    chk("t1_bd_clear", 32'(burst_done), 32'd0);
    chk("t1_idle", 32'(dbg_state), 32'(IDLE));

    // 2: one-cycle grant latency, release on valid drop
    s_valid = 4'b1000;
    step();
    chk_grant("t2_gnt", 3, 1'b1, 1'b0);
    step();
    step();
    chk("t2_cnt", 32'(dbg_cnt), 32'd2);
    s_valid = '0;
    step();
    chk_grant("t2_rel", 3, 1'b0, 1'b1);
    chk("t2_ptr", 32'(dbg_ptr), 32'd0);
    step();

    // 3: lone requester sees exactly one idle bubble between bursts
    s_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_grant($sformatf("t3_k%0d", k), 0, (k != 4), (k == 4));
    end
    s_valid = '0;
    step();
    chk("t3_ptr", 32'(dbg_ptr), 32'd1);
    step();

    // 4: counter advances only on handshakes
    s_valid = 4'b0100;
    s_ready = 4'b0000;
    step();
    chk_grant("t4_gnt", 2, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("t4_stall_cnt", 32'(dbg_cnt), 32'd0);
    chk_grant("t4_stall", 2, 1'b1, 1'b0);
    s_ready = 4'b0100;
    step();
    step();
    step();
    chk("t4_cnt3", 32'(dbg_cnt), 32'd3);
    chk("t4_gv3", 32'(grant_vld), 32'd1);
    step();
    chk_grant("t4_rel", 2, 1'b0, 1'b1);
    step();
    chk_grant("t4_regnt", 2, 1'b1, 1'b0);
    s_valid = '0;
    step();
    chk("t4_ptr", 32'(dbg_ptr), 32'd3);
    step();

    // 5: clock-enable freeze mid-burst and right after a release pulse
    s_valid = 4'b0010;
    s_ready = 4'b1111;
    step();
    chk_grant("t5_gnt", 1, 1'b1, 1'b0);
    step();
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_grant($sformatf("t5_frz%0d", k), 1, 1'b1, 1'b0);
      chk($sformatf("t5_frz%0d_cnt", k), 32'(dbg_cnt), 32'd1);
    end
    clk_en = 1'b1;
    step();
    step();
    chk("t5_cnt3", 32'(dbg_cnt), 32'd3);
    step();
    chk_grant("t5_rel", 1, 1'b0, 1'b1);
    clk_en = 1'b0;
    step();
    chk_grant("t5_bdclr", 1, 1'b0, 1'b0);
    chk("t5_bdclr_state", 32'(dbg_state), 32'(IDLE));
    clk_en = 1'b1;
    step();
    chk_grant("t5_regnt", 1, 1'b1, 1'b0);
    s_valid = '0;
    step();
    chk("t5_ptr", 32'(dbg_ptr), 32'd2);
    step();

    // 6: synchronous reset mid-grant, regrant from ptr=0
    s_valid = 4'b1001;
    step();
    chk_grant("t6_gnt", 3, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    chk_grant("t6_rst", 0, 1'b0, 1'b0);
    chk("t6_rst_ptr", 32'(dbg_ptr), 32'd0);
    chk("t6_rst_cnt", 32'(dbg_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    chk_grant("t6_regnt", 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_pipe_rr_addr_arbiter.md
Name:
data_pipe_rr_addr_arbiter

Overview:
- Round-robin arbiter that generates the `addr` select for the multi-slaver-to-single-master pipe interconnect (data_pipe_interconnect_M2S_verb).
- Sits directly upstream of that interconnect's `addr` input.
- Watches the valid vector of the NUM slaver streams and the ready vector the interconnect returns.
- Locks a grant for up to MAX_BURST beats, then rotates fairly to the next requester.

Parameters:
- NUM, 8: number of upstream streams. Legal range 2..32; need not be a power of two.
- NSIZE, derived from NUM (1/2/3/4/5 for NUM <=2/4/8/16/32): width of `addr`.
- MAX_BURST, 16: maximum beats per grant. 0 means no limit; the grant is held until the source drops valid.
- CSIZE, derived ceil(log2(MAX_BURST+1)), minimum 1: beat counter width.

Ports:
- clock  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clk_en  in  1  global enable; all state frozen when low
- s_valid  in  NUM  valid bit of each upstream stream
- s_ready  in  NUM  ready bit the interconnect drives back to each stream
- addr  out  NSIZE  registered select index to the interconnect
- grant_vld  out  1  registered; a grant is active
- grant_onehot  out  NUM  registered; one-hot of addr when grant_vld=1, all zeros otherwise
- burst_done  out  1  registered one-cycle pulse when a grant releases

Behaviour:
- Reset is synchronous on rst_n, active-low, clocked by clock.
- Reset values: addr=0, grant_vld=0, grant_onehot=0, burst_done=0, beat counter=0, priority pointer ptr=0, state=IDLE.
- Reset asserted mid-burst returns to these values on the next edge.
- Handshake definition: hs = clk_en & grant_vld & s_valid[addr] & s_ready[addr].
- Pick function rr_pick(req, ptr): scan indices ptr, ptr+1, …, NUM-1, 0, …, ptr-1 and return the first index with req set, plus a found flag.
- When clk_en=0, every register holds its value, except burst_done, which clears to 0.
- States (shared enum):
  - IDLE, no grant:
    - If any s_valid is set and clk_en=1: addr <= pick(s_valid, ptr), grant_vld <= 1, counter <= 0; next state GRANT.
    - Latency from first valid to grant_vld is exactly 1 cycle.
  - GRANT, grant active. Release condition, evaluated with clk_en=1:
    - (hs and MAX_BURST!=0 and counter==MAX_BURST-1), or
    - (s_valid[addr]==0).
  - GRANT, while not releasing: counter increments on each hs and saturates at MAX_BURST-1; addr holds.
  - GRANT, on release:
    - burst_done <= 1.
    - ptr <= (addr==NUM-1) ? 0 : addr+1. The released stream gets lowest priority.
    - Evaluate pick(s_valid masked by the released index only when the release was caused by burst completion, ptr_next).
    - If a requester is found: addr <= winner, counter <= 0, stay in GRANT. This is back-to-back regrant with no idle cycle.
    - If none is found: grant_vld <= 0, grant_onehot <= 0, addr holds its last value, next state IDLE.
  - Burst-limited release when only the released stream is still requesting: the masked pick finds nothing, so go to IDLE. The next cycle in IDLE regrants the same stream, giving one idle bubble.
- addr only changes on a clock edge.
- A beat handshaked in the same cycle as a release belongs to the old addr. The interconnect latches its path at capture, so this is safe.
- Any state value not listed decodes to IDLE on the next edge.
- s_ready bits of non-granted streams are ignored.

Decomposition:
- Package data_pipe_arb_pkg holds:
  - the state enum {IDLE, GRANT};
  - a function computing NSIZE/CSIZE from NUM/MAX_BURST;
  - the wrap-increment function for ptr.
- Sub-module data_pipe_rr_pick: purely combinational.
  - Inputs: req[NUM], ptr[NSIZE].
  - Outputs: idx[NSIZE], found.
  - Instantiated once in the top.

Test Plan:
1. NUM=4, MAX_BURST=4, ptr=0. s_valid=4'b0110 steady, s_ready=all 1.
   -> addr=1 for 4 beats, then burst_done pulse, then addr=2 for 4 beats, then addr=1.
   -> grant_vld stays 1 throughout with no gap.
2. IDLE, s_valid=4'b1000 asserted at cycle 10.
   -> grant_vld=1 and addr=3 at cycle 11.
   -> Drop s_valid at cycle 13: release, burst_done=1 at cycle 14, grant_vld=0 at cycle 14.
3. Single requester s_valid=4'b0001, MAX_BURST=4.
   -> After 4 handshakes grant_vld=0 for exactly 1 cycle, then addr=0 is regranted.
4. Grant on stream 2 with s_ready[2]=0 for 5 cycles, then 1.
   -> Counter advances only on hs; release happens after 4 actual handshakes, not after 4 cycles.
5. clk_en=0 for 3 cycles mid-burst with s_valid held.
   -> addr, counter and grant_vld are unchanged and burst_done=0.
   -> The burst resumes and completes its remaining beats.
6. Assert rst_n=0 for one cycle mid-grant on addr=3.
   -> Next cycle: addr=0, grant_vld=0, grant_onehot=0, ptr=0.
   -> Regrant occurs from ptr=0 the cycle after reset is released.
